fb_arbiter: RTL
===============

// Module: fb_arbiter
// PURPOSE
//  Shares one single-port frame-buffer memory between the VGA scan-out stream and the GPU draw-engine writer.
//  Prefetches 16-bit words (4 gray pixels each) into a small FIFO and serves the VGA pixel interface.
//  Arbitrates write requests in between reads, with read priority when the prefetch FIFO runs low.
//  Sits between vga (frame_next_pixel/frame_reset/frame_pixel) and the memory controller.
// PARAMETERS
//  ADDR_WIDTH  17     word address width of the memory port
//  FB_WORDS    120000 words per frame; reads never go past FB_WORDS-1
//  FIFO_DEPTH  4      prefetch FIFO depth in words (power of 2, >=2)
//  LOW_WATER   2      FIFO level below which reads beat pending writes
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   asynchronous active-low reset
//  frame_next_pixel_in  in   1   rising edge advances to the next pixel
//  frame_reset_in       in   1   high: rewind the read pointer to word 0 and flush the FIFO
//  frame_pixel_out      out  4   current pixel
//  underrun_out         out  1   sticky flag: a pixel was needed while the FIFO was empty
//  wr_valid_in          in   1   writer request; addr/data held stable until accepted
//  wr_addr_in           in   ADDR_WIDTH  write word address
//  wr_data_in           in   16  write data
//  wr_ready_out         out  1   one-cycle accept pulse
//  mem_req_out          out  1   memory request; held until mem_ack_in
//  mem_we_out           out  1   1 = write, 0 = read
//  mem_addr_out         out  ADDR_WIDTH  memory word address
//  mem_wdata_out        out  16  memory write data
//  mem_ack_in           in   1   one-cycle completion; mem_rdata_in is valid in this cycle
//  mem_rdata_in         in   16  read data
// BEHAVIOUR
//  Reset (rst_n low, async)
//  - All outputs are 0; FSM goes to IDLE; FIFO is empty; rd_addr=0; head_valid=0; sub=0.
//  Pixel path
//  - Rising edge on frame_next_pixel_in is detected by a 1-cycle registered compare (in & ~prev).
//  - frame_pixel_out = head[4*sub+:4] when head_valid, else 0. Nibble 0 (bits 3:0) is shown first.
//  - Each edge increments sub (2 bits). On 3->0, head is loaded from the FIFO pop.
//  - If the FIFO is empty on that pop: head_valid<=0 and underrun_out<=1.
//  - When head_valid=0 and the FIFO is non-empty, head is loaded from the FIFO and head_valid<=1.
//  - While frame_reset_in is high, edges are ignored.
//  - First cycle of frame_reset_in high (registered rising edge):
//    flush FIFO, rd_addr<=0, sub<=0, head_valid<=0, underrun_out<=0.
//    Any read in flight is tagged stale; its ack data is discarded.
//  - Prefetch continues while frame_reset_in is high, so word 0 is in head before reset falls.
//  Arbiter FSM (IDLE, READ, WRITE)
//  - Read eligible: (FIFO count + read in flight) < FIFO_DEPTH and rd_addr < FB_WORDS.
//  - IDLE: if read eligible and count < LOW_WATER -> READ.
//    Else if wr_valid_in -> WRITE. Else if read eligible -> READ. Else stay in IDLE.
//  - READ/WRITE: mem_req_out=1 with addr/we/wdata stable.
//    READ uses mem_addr_out=rd_addr; WRITE uses the wr_*_in values.
//  - On mem_ack_in: READ pushes mem_rdata_in (unless stale) and rd_addr<=rd_addr+1.
//    WRITE pulses wr_ready_out for that same cycle. Next state is IDLE and mem_req_out drops.
//  - mem_req_out is never high in IDLE, so there are at least 2 cycles per transaction.
//  - FIFO push and pop in the same cycle: count is unchanged.
//  - rd_addr stops at FB_WORDS; it does not wrap. Only frame_reset_in rewinds it.
//  - frame_reset_in during WRITE: the write completes normally.
//  - Writes are not bounds-checked against FB_WORDS.
// TESTING
//  1. mem[0]=16'h4321, mem[1]=16'h8765, ack latency 2, frame_reset_in high then low
//     -> pixel 1; after edges: 2,3,4,5; underrun_out=0.
//  2. FIFO full (count=4), wr_valid_in with addr 5, data 16'hBEEF
//     -> WRITE issued next; mem_addr_out=5; wr_ready_out high exactly 1 cycle, at ack.
//  3. count=1 (<LOW_WATER) and wr_valid_in held high
//     -> READ is issued before WRITE; the write is accepted afterwards.
//  4. ack latency 40, one edge every 2 cycles
//     -> underrun_out=1, pixel 0; cleared by the next frame_reset_in.
//  5. frame_reset_in rises during a READ of addr 9
//     -> ack data discarded; next READ addr 0; first pixel = mem[0][3:0].
//  6. FB_WORDS=8, no edges after fill, then 40 edges
//     -> exactly 8 reads (addr 0..7) per frame. rst_n low mid-WRITE -> mem_req_out=0 immediately.

Source files
------------

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Shares one single-port frame-buffer memory between the VGA scan-out stream
// and the GPU draw-engine writer. Reads prefetch 16-bit words (four 4-bit
// gray pixels each) into a small FIFO that feeds the pixel output. Writes are
// slotted in between reads. Reads win whenever the FIFO level drops below
// LOW_WATER.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_next_pixel_in   rising edge advances to the next pixel
//   frame_reset_in        rewinds the read pointer to word 0, flushes the FIFO
//   frame_pixel_out       current 4-bit pixel (0 when no word is loaded)
//   underrun_out          sticky: a pixel was needed while the FIFO was empty
//   wr_valid_in/addr/data writer request, held stable until accepted
//   wr_ready_out          one-cycle accept pulse (coincides with mem_ack_in)
//   mem_req_out/we/addr/wdata  memory request, held until mem_ack_in
//   mem_ack_in, mem_rdata_in   one-cycle completion with read data
// ---------------------------------------------------------------------------
module fb_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int FB_WORDS   = 120000,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WATER  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_next_pixel_in,
  input  logic                  frame_reset_in,
  output logic [3:0]            frame_pixel_out,
  output logic                  underrun_out,
  input  logic                  wr_valid_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [15:0]           wr_data_in,
  output logic                  wr_ready_out,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [15:0]           mem_wdata_out,
  input  logic                  mem_ack_in,
  input  logic [15:0]           mem_rdata_in
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  LOW_C   = CW'(LOW_WATER);
  localparam logic [AW1-1:0] LIMIT_C = AW1'(FB_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_npPrev;
  logic                    r_frPrev;
  logic [15:0]             r_fifo [FIFO_DEPTH];
  logic [PW-1:0]           r_wrPtr;
  logic [PW-1:0]           r_rdPtr;
  logic [CW-1:0]           r_count;
  logic [15:0]             r_head;
  logic                    r_headValid;
  logic [1:0]              r_sub;
  logic                    r_underrun;
  logic [ADDR_WIDTH-1:0]   r_rdAddr;
  logic                    r_stale;
  logic [ADDR_WIDTH-1:0]   r_memAddr;
  logic [15:0]             r_memWdata;

  logic w_npEdge;
  logic w_frRise;
  logic w_readInFlight;
  logic w_rdElig;
  logic w_ackRead;
  logic w_push;
  logic w_pop;
  logic w_underrunEvt;

  // Edge detectors; pixel edges are ignored for as long as frame reset is high.
  assign w_npEdge = frame_next_pixel_in & ~r_npPrev & ~frame_reset_in;
  assign w_frRise = frame_reset_in & ~r_frPrev;

  // A read may only start if its data is guaranteed a FIFO slot. No read starts
  // in the rewind cycle itself, so the latched address is always post-rewind.
  assign w_readInFlight = (r_state == READ);
  assign w_rdElig = (({1'b0, r_count} + {{CW{1'b0}}, w_readInFlight}) < {1'b0, DEPTH_C})
                    && ({1'b0, r_rdAddr} < LIMIT_C) && !w_frRise;

  // Data from a read that was in flight across a frame rewind is dropped.
  assign w_ackRead     = (r_state == READ) && mem_ack_in;
  assign w_push        = w_ackRead && !r_stale && !w_frRise;
  assign w_pop         = !w_frRise && (r_count != '0)
                         && ((w_npEdge && (r_sub == 2'd3)) || !r_headValid);
  assign w_underrunEvt = !w_frRise && w_npEdge && (r_sub == 2'd3) && (r_count == '0);

  assign frame_pixel_out = r_headValid ? r_head[{r_sub, 2'b00} +: 4] : 4'd0;
  assign underrun_out    = r_underrun;
  assign mem_addr_out    = r_memAddr;
  assign mem_wdata_out   = r_memWdata;

  // Input history for the edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_npPrev <= 1'b0;
      r_frPrev <= 1'b0;
    end else begin
      r_npPrev <= frame_next_pixel_in;
      r_frPrev <= frame_reset_in;
    end
  end

  // FIFO storage carries no reset; only the pointers and the level matter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= mem_rdata_in;
    end
  end

  // FIFO pointers and level; push and pop together leave the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_frRise) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Pixel path: the head word is shown nibble 0 first; a new word is pulled
  // on the 3->0 wrap of sub, or whenever the head is empty and data exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_headValid <= 1'b0;
      r_sub       <= '0;
      r_underrun  <= 1'b0;
    end else if (w_frRise) begin
      r_headValid <= 1'b0;
      r_sub       <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_npEdge) r_sub <= r_sub + 2'd1;
      if (w_pop) begin
        r_head      <= r_fifo[r_rdPtr];
        r_headValid <= 1'b1;
      end else if (w_underrunEvt) begin
        r_headValid <= 1'b0;
        r_underrun  <= 1'b1;
      end
    end
  end

  // Read pointer: stops at FB_WORDS and only a frame rewind brings it back.
  // A rewind during a read marks that read stale so its ack is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdAddr <= '0;
      r_stale  <= 1'b0;
    end else if (w_frRise) begin
      r_rdAddr <= '0;
      r_stale  <= (r_state == READ) && !mem_ack_in;
    end else if (w_ackRead) begin
      r_stale <= 1'b0;
      if (!r_stale) r_rdAddr <= r_rdAddr + ADDR_WIDTH'(1);
    end
  end

  // Request address/data are latched at issue so they stay stable even if
  // the read pointer is rewound while the request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else if (r_state == IDLE) begin
      if (w_nextState == READ) begin
        r_memAddr  <= r_rdAddr;
        r_memWdata <= '0;
      end else if (w_nextState == WRITE) begin
        r_memAddr  <= wr_addr_in;
        r_memWdata <= wr_data_in;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Arbiter next state and request outputs. Every transaction returns to
  // IDLE, so the request always drops for at least one cycle in between.
  always_comb begin
    w_nextState  = r_state;
    mem_req_out  = 1'b0;
    mem_we_out   = 1'b0;
    wr_ready_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rdElig && (r_count < LOW_C)) w_nextState = READ;
        else if (wr_valid_in)              w_nextState = WRITE;
        else if (w_rdElig)                 w_nextState = READ;
      end
      READ: begin
        mem_req_out = 1'b1;
        if (mem_ack_in) w_nextState = IDLE;
      end
      WRITE: begin
        mem_req_out  = 1'b1;
        mem_we_out   = 1'b1;
        wr_ready_out = mem_ack_in;
        if (mem_ack_in) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule
